// File: rtl/fade_scanner.sv
// fade_scanner: bouncing-head animation with a geometric fade trail across 24 display columns
module fade_scanner #(
  parameter int TICK_DIV    = 1000000,
  parameter int DECAY_SHIFT = 2,
  parameter int HEAD_LEVEL  = 255,
  parameter int HOLD_TICKS  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] pwm_1_l, output logic [7:0] pwm_1_m, output logic [7:0] pwm_1_r,
  output logic [7:0] pwm_2_l, output logic [7:0] pwm_2_m, output logic [7:0] pwm_2_r,
  output logic [7:0] pwm_3_l, output logic [7:0] pwm_3_m, output logic [7:0] pwm_3_r,
  output logic [7:0] pwm_4_l, output logic [7:0] pwm_4_m, output logic [7:0] pwm_4_r,
  output logic [7:0] pwm_5_l, output logic [7:0] pwm_5_m, output logic [7:0] pwm_5_r,
  output logic [7:0] pwm_6_l, output logic [7:0] pwm_6_m, output logic [7:0] pwm_6_r,
  output logic [7:0] pwm_7_l, output logic [7:0] pwm_7_m, output logic [7:0] pwm_7_r,
  output logic [7:0] pwm_8_l, output logic [7:0] pwm_8_m, output logic [7:0] pwm_8_r,
  output logic       tick,
  output logic [4:0] head_pos,
  output logic       dir_down
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int HW = HOLD_TICKS > 0 ? $clog2(HOLD_TICKS + 1) : 1;
  typedef enum logic [2:0] {IDLE, RUN_UP, RUN_DN, HOLD_HI, HOLD_LO} state_t;
  state_t          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic [4:0]      head_q, head_d;
  logic            dir_q, dir_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            wr;
  logic [7:0]      lvl_q [24];
  logic [7:0]      lvl_d [24];
  // Small levels still fade by at least one step so the trail always reaches 0.
  function automatic logic [7:0] decay(input logic [7:0] v);
    logic [7:0] s;
    s = v >> DECAY_SHIFT;
    return v - ((s == 8'd0) ? {7'd0, v != 8'd0} : s);
  endfunction
  always_comb begin
    tick_d = cnt_q == CW'(TICK_DIV - 1);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    st_d   = st_q;
    head_d = head_q;
    dir_d  = dir_q;
    hold_d = hold_q;
    wr     = 1'b0;
    if (tick_q) begin
      if (!enable) begin
        st_d   = IDLE;
        head_d = 5'd0;
        dir_d  = 1'b0;
      end else begin
        case (st_q)
          IDLE: begin
            head_d = 5'd0;
            dir_d  = 1'b0;
            wr     = 1'b1;
            st_d   = RUN_UP;
          end
          RUN_UP: begin
            head_d = head_q + 5'd1;
            wr     = 1'b1;
            if (head_q == 5'd22) begin
              st_d   = HOLD_HI;
              hold_d = HW'(HOLD_TICKS);
            end
          end
          RUN_DN: begin
            head_d = head_q - 5'd1;
            wr     = 1'b1;
            if (head_q == 5'd1) begin
              st_d   = HOLD_LO;
              hold_d = HW'(HOLD_TICKS);
            end
          end
          HOLD_HI: begin
            wr = 1'b1;
            if (hold_q != '0) hold_d = hold_q - 1'b1;
            else begin
              head_d = 5'd22;
              dir_d  = 1'b1;
              st_d   = RUN_DN;
            end
          end
          HOLD_LO: begin
            wr = 1'b1;
            if (hold_q != '0) hold_d = hold_q - 1'b1;
            else begin
              head_d = 5'd1;
              dir_d  = 1'b0;
              st_d   = RUN_UP;
            end
          end
          default: st_d = IDLE;
        endcase
      end
    end
    for (int k = 0; k < 24; k++)
      lvl_d[k] = !tick_q ? lvl_q[k] : (wr && head_d == 5'(k)) ? 8'(HEAD_LEVEL) : decay(lvl_q[k]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      head_q <= 5'd0;
      dir_q  <= 1'b0;
      hold_q <= '0;
      lvl_q  <= '{default: 8'd0};
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      head_q <= head_d;
      dir_q  <= dir_d;
      hold_q <= hold_d;
      lvl_q  <= lvl_d;
    end
  end
  assign tick     = tick_q;
  assign head_pos = head_q;
  assign dir_down = dir_q;
  assign pwm_1_l = lvl_q[0];  assign pwm_1_m = lvl_q[1];  assign pwm_1_r = lvl_q[2];
  assign pwm_2_l = lvl_q[3];  assign pwm_2_m = lvl_q[4];  assign pwm_2_r = lvl_q[5];
  assign pwm_3_l = lvl_q[6];  assign pwm_3_m = lvl_q[7];  assign pwm_3_r = lvl_q[8];
  assign pwm_4_l = lvl_q[9];  assign pwm_4_m = lvl_q[10]; assign pwm_4_r = lvl_q[11];
  assign pwm_5_l = lvl_q[12]; assign pwm_5_m = lvl_q[13]; assign pwm_5_r = lvl_q[14];
  assign pwm_6_l = lvl_q[15]; assign pwm_6_m = lvl_q[16]; assign pwm_6_r = lvl_q[17];
  assign pwm_7_l = lvl_q[18]; assign pwm_7_m = lvl_q[19]; assign pwm_7_r = lvl_q[20];
  assign pwm_8_l = lvl_q[21]; assign pwm_8_m = lvl_q[22]; assign pwm_8_r = lvl_q[23];
endmodule

// File: tb/tb_fade_scanner.sv
// tb_fade_scanner: directed checks of a HOLD_TICKS=2 and a HOLD_TICKS=0 scanner run side by side
module tb_fade_scanner;
  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [7:0] a [24];
  logic [7:0] b [24];
  logic       t2, t0, d2, d0;
  logic [4:0] h2, h0;
  int         errors = 0, checks = 0;
  int         dec_tab [21] = '{255, 192, 144, 108, 81, 61, 46, 35, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};
  int         h0_tab [5] = '{21, 22, 23, 22, 21};
  int         eh, ed, ec;
  always #5 clk = ~clk;
  fade_scanner #(.TICK_DIV(4), .DECAY_SHIFT(2), .HEAD_LEVEL(255), .HOLD_TICKS(2)) u2 (
    .clk(clk), .reset(reset), .enable(enable),
    .pwm_1_l(a[0]),  .pwm_1_m(a[1]),  .pwm_1_r(a[2]),
    .pwm_2_l(a[3]),  .pwm_2_m(a[4]),  .pwm_2_r(a[5]),
    .pwm_3_l(a[6]),  .pwm_3_m(a[7]),  .pwm_3_r(a[8]),
    .pwm_4_l(a[9]),  .pwm_4_m(a[10]), .pwm_4_r(a[11]),
    .pwm_5_l(a[12]), .pwm_5_m(a[13]), .pwm_5_r(a[14]),
    .pwm_6_l(a[15]), .pwm_6_m(a[16]), .pwm_6_r(a[17]),
    .pwm_7_l(a[18]), .pwm_7_m(a[19]), .pwm_7_r(a[20]),
    .pwm_8_l(a[21]), .pwm_8_m(a[22]), .pwm_8_r(a[23]),
    .tick(t2), .head_pos(h2), .dir_down(d2)
  );
  fade_scanner #(.TICK_DIV(4), .DECAY_SHIFT(2), .HEAD_LEVEL(255), .HOLD_TICKS(0)) u0 (
    .clk(clk), .reset(reset), .enable(enable),
    .pwm_1_l(b[0]),  .pwm_1_m(b[1]),  .pwm_1_r(b[2]),
    .pwm_2_l(b[3]),  .pwm_2_m(b[4]),  .pwm_2_r(b[5]),
    .pwm_3_l(b[6]),  .pwm_3_m(b[7]),  .pwm_3_r(b[8]),
    .pwm_4_l(b[9]),  .pwm_4_m(b[10]), .pwm_4_r(b[11]),
    .pwm_5_l(b[12]), .pwm_5_m(b[13]), .pwm_5_r(b[14]),
    .pwm_6_l(b[15]), .pwm_6_m(b[16]), .pwm_6_r(b[17]),
    .pwm_7_l(b[18]), .pwm_7_m(b[19]), .pwm_7_r(b[20]),
    .pwm_8_l(b[21]), .pwm_8_m(b[22]), .pwm_8_r(b[23]),
    .tick(t0), .head_pos(h0), .dir_down(d0)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int cnt_eq(input logic [7:0] v [24], input int x);
    int n = 0;
    for (int k = 0; k < 24; k++) if (int'(v[k]) == x) n++;
    return n;
  endfunction
  // Returns at the falling edge just after the next tick-action edge.
  task automatic adv();
    int n = 0;
    while (!t2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("tick_timeout", n, 0);
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_pwm_zero", cnt_eq(a, 0), 24);
    chk("rst_head", h2, 0);
    chk("rst_dir", d2, 0);
    chk("rst_tick", t2, 0);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk($sformatf("tick_c%0d", n), t2, (n % 4 == 0) ? 1 : 0);
    end
    enable = 1'b1;
    for (int t = 1; t <= 52; t++) begin
      adv();
      eh = t <= 24 ? t - 1 : t <= 26 ? 23 : t <= 49 ? 49 - t : t <= 51 ? 0 : 1;
      ed = (t >= 27 && t <= 51) ? 1 : 0;
      ec = t <= 21 ? dec_tab[t-1] : t <= 48 ? 0 : t <= 51 ? 255 : 192;
      chk($sformatf("head_t%0d", t), h2, eh);
      chk($sformatf("dir_t%0d", t), d2, ed);
      chk($sformatf("col0_t%0d", t), a[0], ec);
      if (t == 2) chk("col1_t2", a[1], 255);
      if (t >= 24 && t <= 26) chk($sformatf("dwell23_t%0d", t), a[23], 255);
      if (t == 27) chk("col23_t27", a[23], 192);
      if (t >= 22 && t <= 26) chk($sformatf("h0_head_t%0d", t), h0, h0_tab[t-22]);
      if (t == 24) chk("h0_col23_t24", b[23], 255);
      if (t == 25) chk("h0_dir_t25", d0, 1);
    end
    repeat (9) adv();
    chk("head_at10", h2, 10);
    enable = 1'b0;
    adv();
    chk("drop_head", h2, 0);
    chk("drop_dir", d2, 0);
    chk("drop_no255_u2", cnt_eq(a, 255), 0);
    chk("drop_no255_u0", cnt_eq(b, 255), 0);
    chk("drop_col10", a[10], 192);
    repeat (19) adv();
    chk("fade_zero_u2", cnt_eq(a, 0), 24);
    chk("fade_zero_u0", cnt_eq(b, 0), 24);
    adv();
    chk("stay_zero_u2", cnt_eq(a, 0), 24);
    chk("stay_zero_u0", cnt_eq(b, 0), 24);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    adv();
    chk("glitch_head", h2, 0);
    chk("glitch_col0", a[0], 0);
    enable = 1'b1;
    adv();
    chk("reen_col0", a[0], 255);
    chk("reen_head", h2, 0);
    adv();
    chk("reen_col0_dec", a[0], 192);
    chk("reen_col1", a[1], 255);
    chk("reen_head1", h2, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_pwm_zero", cnt_eq(a, 0), 24);
    chk("mrst_head", h2, 0);
    chk("mrst_dir", d2, 0);
    chk("mrst_tick", t2, 0);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk($sformatf("mrst_tick_c%0d", n), t2, (n == 4) ? 1 : 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fade_scanner.md
Name: fade_scanner

Overview:
- Animation source that generates the 24 per-column brightness levels for the 8-digit seven-segment PWM display driver.
- Each digit has three columns: l (segments f/e), m (segments a/d/g) and r (segments b/c).
- A bright head sweeps across the 24 columns and bounces at both ends, with an optional dwell at each end.
- Every column fades geometrically on each animation tick, leaving a trail. Outputs connect 1:1 to the driver's pwm_<d>_<c> inputs.

Parameters:
- TICK_DIV, 1000000, clk cycles per animation tick; legal range is 2 or more.
- DECAY_SHIFT, 2, per-tick decay is level>>DECAY_SHIFT; legal range 1..7.
- HEAD_LEVEL, 255, 8-bit level written into the head column.
- HOLD_TICKS, 0, extra ticks the head dwells at column 0 and at column 23 before reversing.

Ports:
- clk  input  1  system clock; the block uses only this clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = run the sweep; 0 = stop the head and let the trail fade out.
- pwm_<d>_<c>  output  8  column brightness, for d=1..8 and c=l,m,r (24 ports).
- tick  output  1  one-cycle pulse marking each animation tick.
- head_pos  output  5  current head column, 0..23.
- dir_down  output  1  1 while the head is moving toward column 0.

Behaviour:
- Column numbering: column k maps to digit k/3+1. k%3 = 0 is l, 1 is m, 2 is r. All outputs are registered.
- Reset, sampled on a clk edge with reset=1:
  - all 24 levels = 0
  - prescaler = 0, tick = 0
  - head_pos = 0, dir_down = 0
  - state = IDLE, hold_cnt = 0
  - Reset overrides everything, including mid-sweep.
- Prescaler:
  - Free-runs out of reset, independent of enable.
  - When the count equals TICK_DIV-1, the count returns to 0 and tick <= 1. Otherwise the count increments and tick <= 0.
  - Tick period is exactly TICK_DIV cycles. The first tick is high TICK_DIV cycles after reset deasserts.
- Tick actions: all state and level updates happen only on an edge where tick=1. Results are visible the following cycle.
- Decay, applied to every column on every tick:
  - dec = level>>DECAY_SHIFT; if dec = 0 and level != 0, dec = 1.
  - level <= level - dec. The result never underflows; 0 stays 0.
  - A head write in the same tick overrides decay for that column.
- FSM states: IDLE, RUN_UP, RUN_DN, HOLD_HI, HOLD_LO. On each tick:
  - IDLE, enable=0: decay only, no head write; head_pos = 0.
  - IDLE, enable=1: head_pos <= 0, column 0 <= HEAD_LEVEL, dir_down <= 0, go to RUN_UP.
  - RUN_UP, head_pos < 23: head_pos+1, write head.
  - RUN_UP, head_pos = 22 reaching 23: after writing column 23, go to HOLD_HI with hold_cnt = HOLD_TICKS.
  - HOLD_HI, hold_cnt > 0: rewrite head at 23, hold_cnt-1.
  - HOLD_HI, hold_cnt = 0: head_pos <= 22, write head, dir_down <= 1, go to RUN_DN.
  - With HOLD_TICKS=0, the head therefore sits on column 23 for exactly one tick, like any other column.
  - RUN_DN and HOLD_LO mirror the above: arriving at 0 enters HOLD_LO; leaving HOLD_LO moves to column 1, dir_down <= 0, go to RUN_UP.
  - Any state with enable=0 at a tick: go to IDLE, head_pos <= 0, dir_down <= 0, decay only. In that tick the old head column decays; it is not rewritten.
- enable is sampled only on tick edges. Toggling it between ticks has no effect.
- Full-bounce period with HOLD_TICKS=h: 46+2h ticks.

Test Plan:
- TICK_DIV=4, reset held 3 cycles then released → all pwm = 0, head_pos = 0, dir_down = 0; tick high on cycles 4, 8, 12 after release and low otherwise.
- Decay sequence, TICK_DIV=4, DECAY_SHIFT=2, enable=1 → after tick 1: pwm_1_l = 255. After tick 2: pwm_1_l = 192, pwm_1_m = 255. Column 0 over later ticks follows 144, 108, 81, 61, 46, 35, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0, then stays 0.
- HOLD_TICKS=2, enable held high → head_pos steps 0..23 on successive ticks, stays at 23 for 3 ticks, then goes to 22 with dir_down = 1. At the low end it stays at 0 for 3 ticks, then goes to 1 with dir_down = 0. pwm_8_r = 255 throughout the dwell at 23.
- HOLD_TICKS=0 → head_pos sequence 21, 22, 23, 22, 21; 23 appears for exactly one tick.
- enable dropped mid-sweep at head_pos = 10 → next tick: head_pos = 0, no column written at 255. All 24 columns reach 0 within 21 ticks and remain 0. Re-enabling → column 0 = 255 on the next tick.
- reset asserted for 1 cycle mid-sweep, with nonzero levels and mid-prescale → the next cycle shows all pwm = 0, head_pos = 0, tick = 0. The next tick arrives exactly TICK_DIV cycles after reset deasserts.
